muldiv_unit: RTL



---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_if.sv | 29 ++
 rtl/muldiv_ctrl.sv | 84 ++++++++
 rtl/muldiv_unit.sv | 129 ++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// codes, controller state encoding and the hardwired-zero register index.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Writes to this register index are suppressed.
  localparam int REG_ZERO = 0;

  // Divide-class operations use the restoring divider path.
  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

  // MULHU and REMU return the upper half of the accumulator.
  function automatic logic op_hi_word(input op_e op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request / write-back bundle between the register file read ports, the
// multiply/divide unit and the register file write mux.
interface muldiv_if import muldiv_pkg::*; #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) ();

  logic                  start;
  op_e                   op;
  logic [WIDTH-1:0]      src_a;
  logic [WIDTH-1:0]      src_b;
  logic [REG_ADDR_W-1:0] dest;
  logic                  busy;
  logic                  done;
  logic                  wr_en;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]      wr_data;

  modport master (
    output start, op, src_a, src_b, dest,
    input  busy, done, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  start, op, src_a, src_b, dest,
    output busy, done, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/muldiv_ctrl.sv
// Controller for the multiply/divide unit: IDLE -> RUN -> DONE -> IDLE
// sequencing, iteration counter and registered busy/done/wr_en strobes.
// early_out, when high in IDLE with start, jumps straight to DONE.
module muldiv_ctrl import muldiv_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic early_out,
  input  logic dest_nz,
  output logic accept,
  output logic run,
  output logic enter_done,
  output logic busy,
  output logic done,
  output logic wr_en
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wr_en_q, wr_en_d;

  // State, counter and output strobe registers with synchronous reset.
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wr_en_q <= wr_en_d;
    end
  end

  // Next-state and counter logic.
  // NOTE: defaults first so no path through the case leaves a value unassigned
  // (which would infer a latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = CNT_LAST;
          state_d = early_out ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath controls and next values of the registered strobes.
  always_comb begin
    accept     = (state_q == S_IDLE) && start;
    run        = (state_q == S_RUN);
    enter_done = (state_d == S_DONE);
    busy_d     = (state_d != S_IDLE);
    done_d     = enter_done;
    wr_en_d    = enter_done && dest_nz;
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign wr_en = wr_en_q;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit. One shift-add (MUL/MULHU) or
// restoring-division (DIVU/REMU) step per cycle over a 2*WIDTH accumulator;
// the result is returned as a one-cycle register write request.
// Optional build macro MULDIV_EARLY_OUT_EN: a zero operand skips the
// iteration phase and completes in the cycle after accept.
module muldiv_unit import muldiv_pkg::*; #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  logic [WIDTH-1:0]      a_q, a_d;
  logic [WIDTH-1:0]      b_q, b_d;
  op_e                   op_q, op_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;
  logic [2*WIDTH-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0]      wr_data_q, wr_data_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;

  logic                  accept, run, enter_done;
  logic                  early_out, dest_nz;

  // Iteration temporaries.
  logic [WIDTH:0]        sum;     // upper half plus multiplicand, with carry
  logic [WIDTH:0]        rem_sh;  // partial remainder shifted left one place
  logic [WIDTH-1:0]      diff;
  logic                  fits;

`ifdef MULDIV_EARLY_OUT_EN
  assign early_out = (bus.src_a == '0) || (bus.src_b == '0);
`else
  assign early_out = 1'b0;
`endif

  assign dest_nz = (dest_d != REG_ADDR_W'(REG_ZERO));

  muldiv_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .start      (bus.start),
    .early_out  (early_out),
    .dest_nz    (dest_nz),
    .accept     (accept),
    .run        (run),
    .enter_done (enter_done),
    .busy       (bus.busy),
    .done       (bus.done),
    .wr_en      (bus.wr_en)
  );

  // Operand latch, accumulator iteration and result capture.
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    dest_d    = dest_q;
    acc_d     = acc_q;
    wr_data_d = wr_data_q;
    wr_addr_d = wr_addr_q;
    sum       = '0;
    rem_sh    = '0;
    diff      = '0;
    fits      = 1'b0;

    if (accept) begin
      a_d    = bus.src_a;
      b_d    = bus.src_b;
      op_d   = bus.op;
      dest_d = bus.dest;
      if (early_out) begin
        // Preload what the full algorithm would leave behind.
        if (op_is_div(bus.op) && (bus.src_b == '0))
          acc_d = {bus.src_a, {WIDTH{1'b1}}};
        else
          acc_d = '0;
      end else if (op_is_div(bus.op)) begin
        // {remainder, quotient}; the dividend shifts out of the low half.
        acc_d = {{WIDTH{1'b0}}, bus.src_a};
      end else begin
        // Low half doubles as the multiplier shift register.
        acc_d = {{WIDTH{1'b0}}, bus.src_b};
      end
    end else if (run) begin
      if (!op_is_div(op_q)) begin
        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        acc_d = {sum, acc_q[WIDTH-1:1]};
      end else begin
        rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
        fits   = (rem_sh >= {1'b0, b_q});
        diff   = rem_sh[WIDTH-1:0] - b_q;
        if (fits) acc_d = {diff,               acc_q[WIDTH-2:0], 1'b1};
        else      acc_d = {rem_sh[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b0};
      end
    end

    if (enter_done) begin
      wr_data_d = op_hi_word(op_d) ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];
      wr_addr_d = dest_d;
    end
  end

  // Datapath registers; cleared on reset so the write port reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_MUL;
      dest_q    <= '0;
      acc_q     <= '0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      dest_q    <= dest_d;
      acc_q     <= acc_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign bus.wr_data = wr_data_q;
  assign bus.wr_addr = wr_addr_q;

endmodule
